// File: rtl/hci_hwpe_mux_pkg.sv
// Shared types and helpers for the HWPE port multiplexer.
package hci_hwpe_mux_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } hci_hwpe_mux_state_t;

   localparam int              STALL_W   = 16;
   localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

   // Port-index width; a single port still needs one bit to carry an ID.
   function automatic int hci_id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hci_hwpe_mux_id_fifo.sv
// In-order ID FIFO recording which port owns each in-flight request.
module hci_hwpe_mux_id_fifo
   import hci_hwpe_mux_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;

   // Extra pointer MSB separates full from empty when the indices match.
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head_o  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
         if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem[wr_ptr[PW-1:0]] <= data_i;
   end

endmodule

// File: rtl/hci_hwpe_mux.sv
// N-to-1 HWPE port merger: round-robin arbitration with a bounded burst lock and
// in-order response routing. Define HCI_HWPE_MUX_STALL_CNT_EN for per-port stall counters.
module hci_hwpe_mux
   import hci_hwpe_mux_pkg::*;
#(
   parameter int N_HWPE          = 2,
   parameter int AW              = 32,
   parameter int DW              = 128,
   parameter int BW              = 8,
   parameter int MAX_BURST       = 4,
   parameter int MAX_OUTSTANDING = 8
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic [N_HWPE-1:0]        in_req_i,
   output logic [N_HWPE-1:0]        in_gnt_o,
   input  logic [N_HWPE*AW-1:0]     in_add_i,
   input  logic [N_HWPE-1:0]        in_wen_i,
   input  logic [N_HWPE*DW/BW-1:0]  in_be_i,
   input  logic [N_HWPE*DW-1:0]     in_data_i,
   output logic [DW-1:0]            in_r_data_o,
   output logic [N_HWPE-1:0]        in_r_valid_o,
   output logic                     out_req_o,
   input  logic                     out_gnt_i,
   output logic [AW-1:0]            out_add_o,
   output logic                     out_wen_o,
   output logic [DW/BW-1:0]         out_be_o,
   output logic [DW-1:0]            out_data_o,
   input  logic [DW-1:0]            out_r_data_i,
   input  logic                     out_r_valid_i,
`ifdef HCI_HWPE_MUX_STALL_CNT_EN
   output logic [N_HWPE*STALL_W-1:0] stall_cnt_o,
`endif
   output logic                     err_o
);

   localparam int BEW = DW / BW;
   localparam int IDW = hci_id_width(N_HWPE);
   localparam int BCW = $clog2(MAX_BURST + 1);

   hci_hwpe_mux_state_t state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] owner;
   logic [IDW-1:0] arb_winner;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] head;
   logic [BCW-1:0] burst_cnt;
   logic [BCW-1:0] burst_nxt;
   logic           fifo_full;
   logic           fifo_empty;
   logic           hs;
   logic           pop;

   // Reverse scan: the last hit is the first requester at or after rr_ptr.
   always_comb begin
      int idx;
      // NOTE: defaults first so no path leaves a combinational variable unassigned (no latch).
      idx        = 0;
      arb_winner = '0;
      for (int k = N_HWPE - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % N_HWPE;
         if (in_req_i[idx]) arb_winner = IDW'(idx);
      end
   end

   always_comb begin
      if (state == LOCK && in_req_i[owner]) winner = owner;
      else                                  winner = arb_winner;
   end

   // Full FIFO blocks requests regardless of a same-cycle pop: no r_valid->req path.
   assign out_req_o = (|in_req_i) & ~fifo_full & ~rst_i;
   assign hs        = out_req_o & out_gnt_i;
   assign pop       = out_r_valid_i & ~fifo_empty;

   always_comb begin
      out_add_o    = '0;
      out_wen_o    = 1'b0;
      out_be_o     = '0;
      out_data_o   = '0;
      in_gnt_o     = '0;
      in_r_valid_o = '0;
      in_r_data_o  = '0;
      if (!rst_i) begin
         in_r_data_o = out_r_data_i;
         for (int i = 0; i < N_HWPE; i++) begin
            if (IDW'(i) == winner) begin
               out_add_o   = in_add_i[i*AW +: AW];
               out_wen_o   = in_wen_i[i];
               out_be_o    = in_be_i[i*BEW +: BEW];
               out_data_o  = in_data_i[i*DW +: DW];
               in_gnt_o[i] = hs;
            end
            in_r_valid_o[i] = pop && (head == IDW'(i));
         end
      end
   end

   assign burst_nxt = (state == LOCK && winner == owner) ? burst_cnt + 1'b1 : BCW'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ARB;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         err_o     <= 1'b0;
      end else if (clear_i) begin
         state     <= ARB;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         err_o     <= 1'b0;
      end else begin
         if (out_r_valid_i && fifo_empty) err_o <= 1'b1;
         if (hs) begin
            rr_ptr    <= IDW'((int'(winner) + 1) % N_HWPE);
            owner     <= winner;
            burst_cnt <= burst_nxt;
            state     <= (int'(burst_nxt) < MAX_BURST) ? LOCK : ARB;
         end else if (!in_req_i[owner]) begin
            state     <= ARB;
            burst_cnt <= '0;
         end
      end
   end

   hci_hwpe_mux_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDW)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (hs),
      .data_i  (winner),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

`ifdef HCI_HWPE_MUX_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cnt [N_HWPE];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_HWPE; i++) stall_cnt[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < N_HWPE; i++) stall_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_HWPE; i++)
            if (in_req_i[i] && !in_gnt_o[i] && stall_cnt[i] != STALL_MAX)
               stall_cnt[i] <= stall_cnt[i] + 1'b1;
      end
   end

   always_comb begin
      stall_cnt_o = '0;
      for (int i = 0; i < N_HWPE; i++) stall_cnt_o[i*STALL_W +: STALL_W] = stall_cnt[i];
   end
`else
   // Stall accounting is compiled out in this build.
`endif

endmodule
